// File: rtl/nn_accuracy_counter.sv
// nn_accuracy_counter: scores the network's per-sample classifications against
// an external label ROM, counts correct/total results over one run and, at run
// end, computes floor(100*correct/total) with a 17-step restoring divider.
module nn_accuracy_counter #(
  parameter int N_SAMPLES = 750,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result,
  input  logic              run_end,
  input  logic [DATA_W-1:0] label_data,
  output logic [CNT_W-1:0]  label_addr,
  output logic [CNT_W-1:0]  correct_cnt,
  output logic [CNT_W-1:0]  total_cnt,
  output logic              last_match,
  output logic              busy,
  output logic [6:0]        accuracy,
  output logic              acc_valid
);

  localparam int NUM_W     = 17;          // holds correct*100, up to 75000
  localparam int REM_W     = CNT_W + 1;   // shifted partial remainder
  localparam int DIV_STEPS = 17;          // one quotient bit per numerator bit

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [4:0]       STEP_LAST = 5'(DIV_STEPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic [NUM_W-1:0]  num_r;    // numerator, shifted out MSB first
  logic [CNT_W-1:0]  rem_r;    // partial remainder, always < total_cnt
  logic [NUM_W-1:0]  quot_r;   // quotient bits, shifted in LSB
  logic [4:0]        step_r;   // division steps performed so far

  logic              match_s;
  logic [CNT_W-1:0]  total_inc_s;
  logic [CNT_W-1:0]  correct_inc_s;
  logic [CNT_W-1:0]  total_next_s;
  logic [CNT_W-1:0]  correct_next_s;
  logic              full_s;
  logic              end_s;
  logic [NUM_W-1:0]  numerator_s;
  logic [REM_W-1:0]  rem_shift_s;
  logic [REM_W-1:0]  trial_s;
  logic              q_bit_s;

  // Scoring of the current sample and the end-of-run decision (post-update counts).
  always_comb begin
    match_s        = (result == label_data);
    total_inc_s    = total_cnt + CNT_ONE;
    correct_inc_s  = correct_cnt + {{(CNT_W-1){1'b0}}, match_s};
    total_next_s   = result_valid ? total_inc_s : total_cnt;
    correct_next_s = result_valid ? correct_inc_s : correct_cnt;
    full_s         = result_valid && (total_inc_s == CNT_MAX);
    end_s          = run_end || full_s;
    numerator_s    = NUM_W'(correct_next_s) * 17'd100;
  end

  // One restoring-division step: shift in the next numerator bit, try subtracting.
  always_comb begin
    rem_shift_s = {rem_r, num_r[NUM_W-1]};
    trial_s     = rem_shift_s - {1'b0, total_cnt};
    q_bit_s     = ~trial_s[REM_W-1];
  end

  // Run/divide/done sequencing; start restarts from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      label_addr  <= CNT_ZERO;
      correct_cnt <= CNT_ZERO;
      total_cnt   <= CNT_ZERO;
      last_match  <= 1'b0;
      busy        <= 1'b0;
      accuracy    <= 7'd0;
      acc_valid   <= 1'b0;
      num_r       <= 17'd0;
      rem_r       <= CNT_ZERO;
      quot_r      <= 17'd0;
      step_r      <= 5'd0;
    end else if (start) begin
      state_r     <= ST_RUN;
      label_addr  <= CNT_ZERO;
      correct_cnt <= CNT_ZERO;
      total_cnt   <= CNT_ZERO;
      last_match  <= 1'b0;
      busy        <= 1'b1;
      accuracy    <= 7'd0;
      acc_valid   <= 1'b0;
      num_r       <= 17'd0;
      rem_r       <= CNT_ZERO;
      quot_r      <= 17'd0;
      step_r      <= 5'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (result_valid) begin
            total_cnt   <= total_inc_s;
            correct_cnt <= correct_inc_s;
            last_match  <= match_s;
            // label_addr tracks total_cnt but wraps exactly when the run fills
            label_addr  <= full_s ? CNT_ZERO : (label_addr + CNT_ONE);
          end
          if (end_s) begin
            if (total_next_s == CNT_ZERO) begin
              state_r   <= ST_DONE;
              busy      <= 1'b0;
              accuracy  <= 7'd0;
              acc_valid <= 1'b1;
            end else begin
              state_r <= ST_DIV;
              num_r   <= numerator_s;
              rem_r   <= CNT_ZERO;
              quot_r  <= 17'd0;
              step_r  <= 5'd0;
            end
          end
        end
        ST_DIV: begin
          if (step_r == STEP_LAST) begin
            // quotient never exceeds 100, so the low 7 bits are the result
            state_r   <= ST_DONE;
            busy      <= 1'b0;
            accuracy  <= quot_r[6:0];
            acc_valid <= 1'b1;
          end else begin
            num_r  <= {num_r[NUM_W-2:0], 1'b0};
            rem_r  <= q_bit_s ? trial_s[CNT_W-1:0] : rem_shift_s[CNT_W-1:0];
            quot_r <= {quot_r[NUM_W-2:0], q_bit_s};
            step_r <= step_r + 5'd1;
          end
        end
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
